// File: rtl/apb_mon_pkg.sv
// Shared types and constants for the APB protocol monitor: phase encoding,
// violation codes and the priority encoder that picks the reported code.
package apb_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } mon_state_e;

    localparam int NUM_ERR = 5;

    localparam logic [2:0] ERR_EN_NO_SETUP = 3'd1;
    localparam logic [2:0] ERR_NO_ACCESS   = 3'd2;
    localparam logic [2:0] ERR_UNSTABLE    = 3'd3;
    localparam logic [2:0] ERR_ABORT       = 3'd4;
    localparam logic [2:0] ERR_TIMEOUT     = 3'd5;

    // Bit n-1 of a violation vector stands for error code n.
    typedef logic [NUM_ERR-1:0] err_vec_t;

    function automatic logic [2:0] lowest_code(input err_vec_t v);
        lowest_code = 3'd0;
        for (int i = NUM_ERR - 1; i >= 0; i--) begin
            if (v[i]) lowest_code = 3'(i + 1);
        end
    endfunction

endpackage

// File: rtl/apb_mon_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear takes priority over
// increment so a coinciding event is dropped.
module apb_mon_sat_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/apb_protocol_monitor.sv
// Passive APB checker: tracks the bus phase, flags ordering, stability, abort
// and wait-state timeout violations, and counts completed transfers.
module apb_protocol_monitor
    import apb_mon_pkg::*;
#(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    input  logic              pready,
    input  logic              pslverr,
    input  logic              clr,
    output logic              err_pulse,
    output logic [2:0]        err_code,
    output logic [4:0]        err_sticky,
    output logic [CNT_W-1:0]  wr_cnt,
    output logic [CNT_W-1:0]  rd_cnt,
    output logic [CNT_W-1:0]  slverr_cnt,
    output logic [1:0]        mon_state
);

    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

    mon_state_e        state, state_nxt;
    logic [ADDR_W-1:0] cap_addr;
    logic              cap_write;
    logic [DATA_W-1:0] cap_wdata;
    logic [7:0]        wait_cnt, wait_nxt;
    logic              capture;
    logic              unstable;
    logic              wr_inc, rd_inc, slverr_inc;
    err_vec_t          viol;

    assign unstable = (paddr != cap_addr) || (pwrite != cap_write)
                   || (cap_write && (pwdata != cap_wdata));

    // NOTE: every signal driven here gets a default before the case, otherwise
    // a path that skips an assignment would infer a latch.
    always_comb begin
        state_nxt  = state;
        wait_nxt   = wait_cnt;
        capture    = 1'b0;
        wr_inc     = 1'b0;
        rd_inc     = 1'b0;
        slverr_inc = 1'b0;
        viol       = '0;
        case (state)
            ST_IDLE: begin
                if (penable) begin
                    viol[ERR_EN_NO_SETUP-1] = 1'b1;
                end else if (psel) begin
                    state_nxt = ST_SETUP;
                    capture   = 1'b1;
                end
            end
            ST_SETUP: begin
                if (psel && penable) begin
                    state_nxt            = ST_ACCESS;
                    viol[ERR_UNSTABLE-1] = unstable;
                    wait_nxt             = 8'd0;
                end else begin
                    viol[ERR_NO_ACCESS-1] = 1'b1;
                    if (psel) capture   = 1'b1;
                    else      state_nxt = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                viol[ERR_UNSTABLE-1] = unstable;
                if (psel && penable) begin
                    if (pready) begin
                        state_nxt  = ST_IDLE;
                        wr_inc     = cap_write;
                        rd_inc     = !cap_write;
                        slverr_inc = pslverr;
                    end else if (wait_cnt < WAIT_LIMIT) begin
                        // Saturation makes the timeout fire only once per transfer.
                        wait_nxt            = wait_cnt + 8'd1;
                        viol[ERR_TIMEOUT-1] = (wait_nxt == WAIT_LIMIT);
                    end
                end else begin
                    viol[ERR_ABORT-1] = 1'b1;
                    state_nxt         = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every process
    // sampling it on this edge sees the pre-edge value.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= ST_IDLE;
            wait_cnt <= 8'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cap_addr  <= '0;
            cap_write <= 1'b0;
            cap_wdata <= '0;
        end else if (capture) begin
            cap_addr  <= paddr;
            cap_write <= pwrite;
            cap_wdata <= pwdata;
        end
    end

    // The pulse and code still report when clr wipes the sticky flags.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err_pulse  <= 1'b0;
            err_code   <= 3'd0;
            err_sticky <= '0;
        end else begin
            err_pulse  <= |viol;
            err_code   <= lowest_code(viol);
            err_sticky <= clr ? '0 : (err_sticky | viol);
        end
    end

    apb_mon_sat_cnt #(.CNT_W(CNT_W)) u_wr_cnt (
        .clk    (clk),
        .resetn (resetn),
        .clr    (clr),
        .inc    (wr_inc),
        .cnt    (wr_cnt)
    );

    apb_mon_sat_cnt #(.CNT_W(CNT_W)) u_rd_cnt (
        .clk    (clk),
        .resetn (resetn),
        .clr    (clr),
        .inc    (rd_inc),
        .cnt    (rd_cnt)
    );

    apb_mon_sat_cnt #(.CNT_W(CNT_W)) u_slverr_cnt (
        .clk    (clk),
        .resetn (resetn),
        .clr    (clr),
        .inc    (slverr_inc),
        .cnt    (slverr_cnt)
    );

    assign mon_state = state;

endmodule
